// File: rtl/bp_pkg.sv
// Shared constants and entry type for the branch-resolution queue.
package bp_pkg;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;
    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;

    localparam int BPRED_WIDTH_DEFAULT = 9;

    typedef struct packed {
        logic [BPRED_WIDTH_DEFAULT-1:0] index;
        logic                           prediction;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order storage for in-flight branch predictions: push at tail, pop at head,
// and a flush that discards everything younger than the entry being popped.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int WIDTH     = BPRED_WIDTH_DEFAULT + 1,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Push,
    input  logic                 i_Pop,
    input  logic                 i_Flush,
    input  logic [WIDTH-1:0]     i_Data,
    output logic [WIDTH-1:0]     o_Head,
    output logic                 o_Full,
    output logic                 o_Empty,
    output logic [PTR_WIDTH:0]   o_Count
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 do_pop;
    logic                 do_push;

    assign o_Full  = (count_q == (PTR_WIDTH+1)'(DEPTH));
    assign o_Empty = (count_q == '0);
    assign o_Count = count_q;
    assign o_Head  = mem_q[head_q];

    // A full queue still accepts a push when the same edge frees the head slot.
    assign do_pop  = i_Pop && !o_Empty;
    assign do_push = i_Push && !(do_pop && i_Flush) && (!o_Full || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = head_q + PTR_WIDTH'(1);
        end
        if (do_pop && i_Flush) begin
            tail_d  = head_q + PTR_WIDTH'(1);
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PTR_WIDTH'(1);
            end
            count_d = count_q + (PTR_WIDTH+1)'(do_push) - (PTR_WIDTH+1)'(do_pop);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (do_push) begin
            mem_q[tail_q] <= i_Data;
        end
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// Resolution-side companion to counter_table: registers the counter update,
// flags mispredicts and keeps a sticky error. Optional stats: BP_RESOLVE_STATS_EN.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int BPRED_WIDTH = BPRED_WIDTH_DEFAULT,
    parameter int DEPTH       = 4,
    parameter int PTR_WIDTH   = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_DEC_Is_Branch,
    input  logic [BPRED_WIDTH-1:0] i_DEC_Index,
    input  logic                   i_DEC_Prediction,
    input  logic                   i_ALU_Branch_Valid,
    input  logic                   i_ALU_Branch_Outcome,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [PTR_WIDTH:0]     o_Count,
    output logic                   o_CT_Enable,
    output logic [BPRED_WIDTH-1:0] o_CT_Index,
    output logic                   o_CT_Outcome,
    output logic                   o_Mispredict,
    output logic                   o_Error,
    output logic [31:0]            o_Stat_Resolved,
    output logic [31:0]            o_Stat_Mispredict
);

    logic [BPRED_WIDTH:0]   head_entry;
    logic [BPRED_WIDTH-1:0] head_index;
    logic                   head_pred;
    logic                   pop_valid;
    logic                   mispredict;

    logic                   ct_enable_q, ct_enable_d;
    logic [BPRED_WIDTH-1:0] ct_index_q, ct_index_d;
    logic                   ct_outcome_q, ct_outcome_d;
    logic                   mispredict_q, mispredict_d;
    logic                   error_q, error_d;

    assign head_index = head_entry[BPRED_WIDTH:1];
    assign head_pred  = head_entry[0];
    assign pop_valid  = i_ALU_Branch_Valid && !o_Empty;
    assign mispredict = pop_valid && (i_ALU_Branch_Outcome != head_pred);

    bp_inflight_fifo #(
        .WIDTH     (BPRED_WIDTH + 1),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Push  (i_DEC_Is_Branch),
        .i_Pop   (i_ALU_Branch_Valid),
        .i_Flush (mispredict),
        .i_Data  ({i_DEC_Index, i_DEC_Prediction}),
        .o_Head  (head_entry),
        .o_Full  (o_Full),
        .o_Empty (o_Empty),
        .o_Count (o_Count)
    );

    always_comb begin
        ct_enable_d  = pop_valid;
        ct_index_d   = ct_index_q;
        ct_outcome_d = ct_outcome_q;
        mispredict_d = mispredict;
        error_d      = error_q;
        if (pop_valid) begin
            ct_index_d   = head_index;
            ct_outcome_d = i_ALU_Branch_Outcome;
        end
        // Full implies non-empty, so any resolve while full is a legal pop.
        if ((i_ALU_Branch_Valid && o_Empty) ||
            (i_DEC_Is_Branch && o_Full && !i_ALU_Branch_Valid)) begin
            error_d = TRUE;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            ct_enable_q  <= FALSE;
            ct_index_q   <= '0;
            ct_outcome_q <= NOT_TAKEN;
            mispredict_q <= FALSE;
            error_q      <= FALSE;
        end else begin
            ct_enable_q  <= ct_enable_d;
            ct_index_q   <= ct_index_d;
            ct_outcome_q <= ct_outcome_d;
            mispredict_q <= mispredict_d;
            error_q      <= error_d;
        end
    end

    assign o_CT_Enable  = ct_enable_q;
    assign o_CT_Index   = ct_index_q;
    assign o_CT_Outcome = ct_outcome_q;
    assign o_Mispredict = mispredict_q;
    assign o_Error      = error_q;

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;

    // Counted on the same edge that raises the pulses, so they move together.
    always_comb begin
        stat_resolved_d   = stat_resolved_q + 32'(pop_valid);
        stat_mispredict_d = stat_mispredict_q + 32'(mispredict);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    assign o_Stat_Resolved   = stat_resolved_q;
    assign o_Stat_Mispredict = stat_mispredict_q;
`else
    assign o_Stat_Resolved   = '0;
    assign o_Stat_Mispredict = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue with hand-computed expectations.
module tb_bp_resolve_queue;

    localparam int BW = 9;
    localparam int PW = 2;

    logic          clk;
    logic          rst;
    logic          is_branch;
    logic [BW-1:0] dec_index;
    logic          dec_pred;
    logic          alu_valid;
    logic          alu_outcome;
    logic          full;
    logic          empty;
    logic [PW:0]   count;
    logic          ct_enable;
    logic [BW-1:0] ct_index;
    logic          ct_outcome;
    logic          mispredict;
    logic          error;
    logic [31:0]   stat_resolved;
    logic [31:0]   stat_mispredict;

    int n_checks;
    int n_passed;
    int exp_resolved;
    int exp_mispredicts;
    logic [BW-1:0] exp_q[$];

    bp_resolve_queue dut (
        .i_Clk                (clk),
        .i_Reset              (rst),
        .i_DEC_Is_Branch      (is_branch),
        .i_DEC_Index          (dec_index),
        .i_DEC_Prediction     (dec_pred),
        .i_ALU_Branch_Valid   (alu_valid),
        .i_ALU_Branch_Outcome (alu_outcome),
        .o_Full               (full),
        .o_Empty              (empty),
        .o_Count              (count),
        .o_CT_Enable          (ct_enable),
        .o_CT_Index           (ct_index),
        .o_CT_Outcome         (ct_outcome),
        .o_Mispredict         (mispredict),
        .o_Error              (error),
        .o_Stat_Resolved      (stat_resolved),
        .o_Stat_Mispredict    (stat_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given push/resolve inputs, then inputs return idle.
    task automatic drive(input logic push, input int idx, input logic pred,
                         input logic pop, input logic outcome);
        is_branch   = push;
        dec_index   = BW'(idx);
        dec_pred    = pred;
        alu_valid   = pop;
        alu_outcome = outcome;
        tick();
        is_branch   = 1'b0;
        alu_valid   = 1'b0;
    endtask

    task automatic expect_update(input string tag, input int idx, input logic outcome,
                                 input logic misp);
        exp_resolved++;
        if (misp) exp_mispredicts++;
        check({tag, "_en"}, 32'(ct_enable), 32'd1);
        check({tag, "_idx"}, 32'(ct_index), 32'(idx));
        check({tag, "_out"}, 32'(ct_outcome), 32'(outcome));
        check({tag, "_misp"}, 32'(mispredict), 32'(misp));
    endtask

    task automatic check_stats(input string tag);
`ifdef BP_RESOLVE_STATS_EN
        check({tag, "_stat_res"}, stat_resolved, 32'(exp_resolved));
        check({tag, "_stat_mis"}, stat_mispredict, 32'(exp_mispredicts));
`else
        check({tag, "_stat_res"}, stat_resolved, 32'd0);
        check({tag, "_stat_mis"}, stat_mispredict, 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_resolved    = 0;
        exp_mispredicts = 0;
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        is_branch = 1'b0; dec_index = '0; dec_pred = 1'b0;
        alu_valid = 1'b0; alu_outcome = 1'b0;
        rst = 1'b0;
        #2;
        do_reset();

        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_en", 32'(ct_enable), 32'd0);
        check("rst_misp", 32'(mispredict), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check_stats("rst");

        // Correct prediction, resolved two cycles after push.
        drive(1, 5, 1, 0, 0);
        check("c_count1", 32'(count), 32'd1);
        drive(0, 0, 0, 0, 0);
        check("c_no_en", 32'(ct_enable), 32'd0);
        drive(0, 0, 0, 1, 1);
        expect_update("c", 5, 1, 0);
        check("c_count0", 32'(count), 32'd0);
        check_stats("c");
        drive(0, 0, 0, 0, 0);
        check("c_en_pulse", 32'(ct_enable), 32'd0);
        check("c_idx_hold", 32'(ct_index), 32'd5);

        // Mispredict flush, with a same-cycle wrong-path push.
        drive(1, 3, 0, 0, 0);
        drive(1, 7, 1, 0, 0);
        drive(1, 9, 1, 0, 0);
        check("m_count3", 32'(count), 32'd3);
        drive(1, 11, 1, 1, 1);
        expect_update("m", 3, 1, 1);
        check("m_count0", 32'(count), 32'd0);
        check("m_empty", 32'(empty), 32'd1);
        check_stats("m");
        drive(0, 0, 0, 0, 0);
        check("m_misp_pulse", 32'(mispredict), 32'd0);
        check("m_err_before", 32'(error), 32'd0);
        drive(0, 0, 0, 1, 0);
        check("m_err_pop_empty", 32'(error), 32'd1);
        check("m_no_update", 32'(ct_enable), 32'd0);
        check("m_idx_hold", 32'(ct_index), 32'd3);
        drive(0, 0, 0, 0, 0);
        check("m_err_sticky", 32'(error), 32'd1);
        check_stats("m2");

        // Asynchronous reset mid-operation, with no clock edge involved.
        drive(1, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("ar_count", 32'(count), 32'd0);
        check("ar_err", 32'(error), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        do_reset();

        // Fill, then push+pop while full, then an illegal push while full.
        drive(1, 20, 1, 0, 0);
        drive(1, 21, 0, 0, 0);
        drive(1, 22, 1, 0, 0);
        drive(1, 23, 0, 0, 0);
        check("f_full", 32'(full), 32'd1);
        check("f_count4", 32'(count), 32'd4);
        drive(1, 12, 0, 1, 1);
        expect_update("f_pp", 20, 1, 0);
        check("f_pp_count", 32'(count), 32'd4);
        check("f_pp_err", 32'(error), 32'd0);
        drive(1, 13, 1, 0, 0);
        check("f_ovf_err", 32'(error), 32'd1);
        check("f_ovf_count", 32'(count), 32'd4);
        drive(0, 0, 0, 1, 0);
        expect_update("f_d1", 21, 0, 0);
        drive(0, 0, 0, 1, 1);
        expect_update("f_d2", 22, 1, 0);
        drive(0, 0, 0, 1, 0);
        expect_update("f_d3", 23, 0, 0);
        drive(0, 0, 0, 1, 0);
        expect_update("f_d4", 12, 0, 0);
        check("f_drained", 32'(empty), 32'd1);
        check_stats("f");
        do_reset();

        // Predicted taken, actually not taken.
        drive(1, 100, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        expect_update("nt", 100, 0, 1);

        // Ten branches through a four-entry queue to exercise pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1, i, i[0], 0, 0);
            exp_q.push_back(BW'(i));
            drive(0, 0, 0, 1, i[0]);
            expect_update("wrap", int'(exp_q.pop_front()), i[0], 0);
            check("wrap_count", 32'(count), 32'd0);
        end
        check("wrap_err", 32'(error), 32'd0);
        check_stats("end");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
Resolution-side companion to counter_table. It records each branch prediction made in DEC (counter index plus predicted direction) in a small in-order queue. When the ALU resolves that branch, it pops the oldest entry and drives the registered update (enable, index, outcome) into counter_table. It also flags a mispredict and flushes younger wrong-path entries.

Parameters:
BPRED_WIDTH, 9, width of counter-table index (must match counter_table)
DEPTH, 4, in-flight branch capacity; power of 2, >= 2
PTR_WIDTH, 2, log2(DEPTH)

Ports:
i_Clk  in  1  clock, rising edge
i_Reset  in  1  asynchronous, active-high reset
i_DEC_Is_Branch  in  1  branch predicted in DEC this cycle (push request)
i_DEC_Index  in  BPRED_WIDTH  counter index used for that prediction
i_DEC_Prediction  in  1  predicted direction, 1 = taken
i_ALU_Branch_Valid  in  1  oldest in-flight branch resolves this cycle (pop request)
i_ALU_Branch_Outcome  in  1  actual direction, 1 = taken
o_Full  out  1  DEPTH entries held (combinational from count)
o_Empty  out  1  zero entries held (combinational from count)
o_Count  out  PTR_WIDTH+1  current occupancy
o_CT_Enable  out  1  registered update strobe to counter_table i_Enable
o_CT_Index  out  BPRED_WIDTH  registered update index to counter_table i_Index
o_CT_Outcome  out  1  registered outcome to counter_table i_ALU_Branch_Outcome
o_Mispredict  out  1  registered, 1-cycle pulse: outcome != stored prediction
o_Error  out  1  sticky: pop when empty, or push when full without pop
o_Stat_Resolved  out  32  resolved-branch count (see Optional Feature)
o_Stat_Mispredict  out  32  mispredict count (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-operation) clears pointers and count. All outputs go to 0, except o_Empty = 1. Queue contents are don't-care after reset.
- Push: on a clock edge with i_DEC_Is_Branch = 1, write {i_DEC_Index, i_DEC_Prediction} at the tail, tail+1, count+1.
- Pop: on a clock edge with i_ALU_Branch_Valid = 1 and not empty, read the head. The next cycle shows o_CT_Enable = 1, o_CT_Index = head index, o_CT_Outcome = i_ALU_Branch_Outcome (latched), and o_Mispredict = (outcome != head prediction). Update latency is 1 cycle after resolution.
- o_CT_Enable and o_Mispredict are single-cycle pulses. o_CT_Index and o_CT_Outcome hold their last value while enable = 0.
- Simultaneous push and pop with no mispredict: both happen and count is unchanged. This is legal even when full, because the pop frees the slot.
- Mispredict flush: in the pop cycle where outcome != head prediction, all entries younger than the head are discarded (tail := head+1 mod DEPTH, count := 0). Any same-cycle push is also dropped as wrong-path. The update to counter_table is still issued.
- Pop when empty: no update, no pointer change, o_Error set.
- Push when full with no pop: push dropped, o_Error set.
- o_Error clears only on reset.
- Pointers wrap modulo DEPTH. Count saturates at neither bound; illegal cases are rejected as above.

Optional Feature:
- Macro BP_RESOLVE_STATS_EN.
- Defined: two 32-bit wrapping counters, cleared on reset. o_Stat_Resolved increments on every issued update; o_Stat_Mispredict increments on every o_Mispredict pulse. Both are registered and change in the same cycle as the pulse.
- Undefined: counters are not built and both ports are tied to 0.

Decomposition:
- Shared package bp_pkg: TAKEN/NOT_TAKEN and TRUE/FALSE constants; BPRED_WIDTH default; bp_entry_t typedef {index[BPRED_WIDTH-1:0], prediction}.
- Sub-module bp_inflight_fifo: storage array, head/tail/count, push/pop/flush, full/empty.
- bp_resolve_queue adds the update registers, mispredict compare, error flag and stats.

Test Plan:
- Reset: hold i_Reset = 1 for 2 cycles, then release -> o_Empty = 1, o_Count = 0, o_CT_Enable = 0, o_Mispredict = 0, o_Error = 0.
- Correct prediction: push (index 5, pred 1), then resolve with outcome 1 two cycles later -> one cycle after resolve, o_CT_Enable = 1, o_CT_Index = 5, o_CT_Outcome = 1, o_Mispredict = 0, o_Count = 0.
- Mispredict flush: push (3, 0), (7, 1), (9, 1); resolve with outcome 1 -> o_CT_Index = 3, o_Mispredict = 1, o_Count = 0 next cycle; a subsequent resolve sets o_Error = 1 and gives no update.
- Full plus simultaneous push/pop: fill to 4 (o_Full = 1). Push (12, 0) with resolve outcome matching the head -> count stays 4, o_Error = 0. Push alone while full -> o_Error = 1.
- Wrap-around: push/pop 10 correctly predicted branches with indices 0..9 -> updates appear in order 0..9 with no error.
- Stats (macro defined): run the sequence above -> o_Stat_Resolved and o_Stat_Mispredict equal the reference-model counts. Macro undefined -> both read 0.
